// File: rtl/fpu_pkg.sv
// Shared widths for the floating-point unpacker: fraction sizes, significand
// width and leading-zero count width.
package fpu_pkg;

    localparam int FRAC_D  = 52;
    localparam int FRAC_S  = 23;
    localparam int SIG_W   = 53;
    localparam int LZ_W    = 6;
    localparam int SGL_PAD = FRAC_D - FRAC_S;

endpackage

// File: rtl/lzc53.sv
// Leading-zero counter for a 53-bit significand, saturating at 53 for zero.
// Purely combinational; shared with the rounder's normalize shifter.
module lzc53
    import fpu_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    output logic [LZ_W-1:0]  lz_o
);

    logic [63:0]     x;
    logic            vld [0:6][0:63];
    logic [LZ_W-1:0] cnt [0:6][0:63];

    // Trailing ones pad the word to 64 bits, so an all-zero significand
    // naturally counts to 53 without a separate saturation path.
    always_comb begin
        x = {sig_i, {(64 - SIG_W){1'b1}}};
        for (int l = 0; l <= 6; l++) begin
            for (int n = 0; n < 64; n++) begin
                vld[l][n] = 1'b0;
                cnt[l][n] = '0;
            end
        end
        for (int n = 0; n < 64; n++) begin
            vld[0][n] = x[n];
        end
        for (int l = 1; l <= 6; l++) begin
            for (int n = 0; n < (64 >> l); n++) begin
                vld[l][n] = vld[l-1][2*n+1] | vld[l-1][2*n];
                cnt[l][n] = vld[l-1][2*n+1] ? cnt[l-1][2*n+1]
                                            : (cnt[l-1][2*n] | LZ_W'(1 << (l - 1)));
            end
        end
    end

    assign lz_o = cnt[6][0];

endmodule

// File: rtl/significand.sv
// Significand unpack: fraction select, hidden bit, lzc, optional normalize.
// One register stage, one operand per cycle, no stall.
module significand
    import fpu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              db,
    input  logic [N-1:0]      fp,
    input  logic              e_z,
    input  logic              normal,
    output logic [LZ_W-1:0]   lz,
    output logic [SIG_W-1:0]  f,
    output logic              fz,
    output logic [FRAC_D-1:0] h
);

    logic [FRAC_D-1:0] h_d, h_q;
    logic [SIG_W-1:0]  f_d, f_q;
    logic [LZ_W-1:0]   lz_d, lz_q;
    logic              fz_d, fz_q;
    logic [SIG_W-1:0]  s;
    logic [LZ_W-1:0]   amt;
    logic              unused_hi;

    assign unused_hi = ^fp[N-1:FRAC_D];

    always_comb begin
        h_d  = db ? fp[FRAC_D-1:0] : {fp[FRAC_S-1:0], {SGL_PAD{1'b0}}};
        fz_d = (h_d == '0);
        s    = {~e_z, h_d};
    end

    lzc53 u_lzc (
        .sig_i (s),
        .lz_o  (lz_d)
    );

    // Log shifter; a zero significand shifts to zero, so no special case.
    always_comb begin
        amt = normal ? lz_d : '0;
        f_d = s;
        for (int i = 0; i < LZ_W; i++) begin
            if (amt[i]) begin
                f_d = f_d << (1 << i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lz_q <= '0;
            f_q  <= '0;
            fz_q <= 1'b0;
            h_q  <= '0;
        end else begin
            lz_q <= lz_d;
            f_q  <= f_d;
            fz_q <= fz_d;
            h_q  <= h_d;
        end
    end

    assign lz = lz_q;
    assign f  = f_q;
    assign fz = fz_q;
    assign h  = h_q;

endmodule

// File: tb/tb_significand.sv
// Directed-vector bench for the significand unpack stage.
module tb_significand;

    logic        clk = 1'b0;
    logic        rst;
    logic        db;
    logic [63:0] fp;
    logic        e_z;
    logic        normal;
    logic [5:0]  lz;
    logic [52:0] f;
    logic        fz;
    logic [51:0] h;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        db;
        logic [63:0] fp;
        logic        e_z;
        logic        nrm;
        logic [5:0]  lz;
        logic [52:0] f;
        logic        fz;
        logic [51:0] h;
    } vec_t;

    vec_t tv [0:11];

    significand #(.N(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .db     (db),
        .fp     (fp),
        .e_z    (e_z),
        .normal (normal),
        .lz     (lz),
        .f      (f),
        .fz     (fz),
        .h      (h)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [5:0] e_lz, input logic [52:0] e_f,
                             input logic e_fz, input logic [51:0] e_h);
        check({tag, ".lz"}, 64'(lz), 64'(e_lz));
        check({tag, ".f"},  64'(f),  64'(e_f));
        check({tag, ".fz"}, 64'(fz), 64'(e_fz));
        check({tag, ".h"},  64'(h),  64'(e_h));
    endtask

    task automatic drive(input int i);
        db     = tv[i].db;
        fp     = tv[i].fp;
        e_z    = tv[i].e_z;
        normal = tv[i].nrm;
    endtask

    initial begin
        //          db    fp                     e_z   nrm   lz     f                      fz    h
        tv[0]  = '{1'b1, 64'h1234567890ABCDEF, 1'b0, 1'b0, 6'd0,  53'h14567890ABCDEF, 1'b0, 52'h4567890ABCDEF};
        tv[1]  = '{1'b1, 64'h000000000000000F, 1'b1, 1'b1, 6'd49, 53'h1E000000000000, 1'b0, 52'hF};
        tv[2]  = '{1'b1, 64'h000000000000000F, 1'b1, 1'b0, 6'd49, 53'hF,              1'b0, 52'hF};
        tv[3]  = '{1'b1, 64'h8000000000000000, 1'b1, 1'b1, 6'd53, 53'h0,              1'b1, 52'h0};
        tv[4]  = '{1'b1, 64'h8000000000000000, 1'b0, 1'b1, 6'd0,  53'h10000000000000, 1'b1, 52'h0};
        tv[5]  = '{1'b0, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b0, 6'd0,  53'h15B7DDE0000000, 1'b0, 52'h5B7DDE0000000};
        tv[6]  = '{1'b0, 64'hFFFFFFFFFFADBEEF, 1'b0, 1'b0, 6'd0,  53'h15B7DDE0000000, 1'b0, 52'h5B7DDE0000000};
        tv[7]  = '{1'b0, 64'h0000000000000001, 1'b1, 1'b1, 6'd23, 53'h10000000000000, 1'b0, 52'h0000020000000};
        tv[8]  = '{1'b1, 64'h0008000000000000, 1'b1, 1'b1, 6'd1,  53'h10000000000000, 1'b0, 52'h8000000000000};
        tv[9]  = '{1'b1, 64'h000000000000000F, 1'b0, 1'b1, 6'd0,  53'h1000000000000F, 1'b0, 52'hF};
        tv[10] = '{1'b1, 64'hFFF0000000000001, 1'b1, 1'b0, 6'd52, 53'h1,              1'b0, 52'h1};
        tv[11] = '{1'b0, 64'hFFFFFFFFFF800000, 1'b1, 1'b0, 6'd53, 53'h0,              1'b1, 52'h0};

        rst = 1'b1;
        drive(0);
        #1;
        check_out("reset", 6'd0, 53'h0, 1'b0, 52'h0);
        #1 rst = 1'b0;

        // Back-to-back operands, one new input per cycle.
        for (int i = 0; i < 12; i++) begin
            drive(i);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tv[i].lz, tv[i].f, tv[i].fz, tv[i].h);
        end

        // Reset between edges clears outputs at once; next edge takes the live input.
        drive(5);
        #2 rst = 1'b1;
        #1;
        check_out("rst_mid", 6'd0, 53'h0, 1'b0, 52'h0);
        #1 rst = 1'b0;
        #1;
        check_out("rst_hold", 6'd0, 53'h0, 1'b0, 52'h0);
        @(posedge clk);
        #1;
        check_out("post_rst", tv[5].lz, tv[5].f, tv[5].fz, tv[5].h);

        drive(1);
        @(posedge clk);
        #1;
        check_out("post_rst2", tv[1].lz, tv[1].f, tv[1].fz, tv[1].h);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
